// File: rtl/time_entry_pkg.sv
// Shared types and limits for the BCD time-entry decoder.
// BCD_TIME_DECODER_HOURS24_EN selects a 23-hour limit instead of 99.
package time_entry_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    CHECK
  } dec_state_t;

  localparam int FIELD_W     = 7;
  localparam int DIGITS      = 6;
  localparam int MAX_MIN_SEC = 59;

`ifdef BCD_TIME_DECODER_HOURS24_EN
  localparam int MAX_HOURS = 23;
`else
  localparam int MAX_HOURS = 99;
`endif

  function automatic logic nib_bad(
    input logic [4*DIGITS-1:0] w
  );
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_time_decoder_rdd_step.sv
// One reverse double-dabble step on a {bcd[7:0], bin[6:0]} register:
// shift right, then subtract 3 from each BCD nibble that reached 8+.
module rdd_step
  import time_entry_pkg::*;
(
  input  logic [8+FIELD_W-1:0] din,
  output logic [8+FIELD_W-1:0] dout
);

  logic [8+FIELD_W-1:0] sh;
  logic [3:0]           hi;
  logic [3:0]           lo;

  assign sh = {1'b0, din[8+FIELD_W-1:1]};

  assign hi = (sh[14:11] >= 4'd8) ? sh[14:11] - 4'd3
                                  : sh[14:11];
  assign lo = (sh[10:7] >= 4'd8) ? sh[10:7] - 4'd3
                                 : sh[10:7];

  assign dout = {hi, lo, sh[FIELD_W-1:0]};

endmodule

// File: rtl/bcd_time_decoder.sv
// Sequential HH:MM:SS packed-BCD to binary decoder with validation.
// BCD_TIME_DECODER_HOURS24_EN limits hours to 23 (default 99).
module bcd_time_decoder
  import time_entry_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic [23:0]        bcd_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [FIELD_W-1:0] hours,
  output logic [FIELD_W-1:0] minutes,
  output logic [FIELD_W-1:0] seconds
);

  localparam logic [FIELD_W-1:0] MS_LIM =
    FIELD_W'(MAX_MIN_SEC);
  localparam logic [FIELD_W-1:0] H_LIM =
    FIELD_W'(MAX_HOURS);

  dec_state_t           state;
  logic [23:0]          bcd_q;
  logic                 dig_err;
  logic [1:0]           fld;
  logic [2:0]           bitc;
  logic [14:0]          wreg;
  logic [14:0]          wnxt;
  logic [FIELD_W-1:0]   sh_s;
  logic [FIELD_W-1:0]   sh_m;
  logic [FIELD_W-1:0]   sh_h;
  logic [7:0]           next_byte;
  logic                 chk_err;

  rdd_step u_step (
    .din  (wreg),
    .dout (wnxt)
  );

  // BCD byte of the field that follows the one just finished
  always_comb begin
    next_byte = 8'h00;
    unique case (fld)
      2'd0:    next_byte = bcd_q[15:8];
      2'd1:    next_byte = bcd_q[23:16];
      default: next_byte = 8'h00;
    endcase
  end

  assign chk_err = dig_err
                 | (sh_m > MS_LIM)
                 | (sh_s > MS_LIM)
                 | (sh_h > H_LIM);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
      bcd_q   <= '0;
      dig_err <= 1'b0;
      fld     <= '0;
      bitc    <= '0;
      wreg    <= '0;
      sh_s    <= '0;
      sh_m    <= '0;
      sh_h    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= start;
          if (start) state <= LOAD;
        end
        LOAD: begin
          bcd_q   <= bcd_in;
          dig_err <= nib_bad(bcd_in);
          fld     <= 2'd0;
          bitc    <= 3'd0;
          wreg    <= {bcd_in[7:0], 7'd0};
          state   <= SHIFT;
        end
        SHIFT: begin
          if (bitc == 3'd6) begin
            unique case (fld)
              2'd0:    sh_s <= wnxt[FIELD_W-1:0];
              2'd1:    sh_m <= wnxt[FIELD_W-1:0];
              default: sh_h <= wnxt[FIELD_W-1:0];
            endcase
            bitc <= 3'd0;
            fld  <= fld + 2'd1;
            wreg <= {next_byte, 7'd0};
            if (fld == 2'd2) state <= CHECK;
          end else begin
            wreg <= wnxt;
            bitc <= bitc + 3'd1;
          end
        end
        CHECK: begin
          done <= 1'b1;
          err  <= chk_err;
          if (!chk_err) begin
            hours   <= sh_h;
            minutes <= sh_m;
            seconds <= sh_s;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_time_decoder.sv
// Randomized bench for bcd_time_decoder against a cycle-count model
// that decodes digits arithmetically.
module tb_bcd_time_decoder;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic [23:0] bcd_in   = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [6:0]  hours;
  logic [6:0]  minutes;
  logic [6:0]  seconds;

`ifdef BCD_TIME_DECODER_HOURS24_EN
  localparam int HLIM = 23;
`else
  localparam int HLIM = 99;
`endif

  bcd_time_decoder dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (start),
    .bcd_in   (bcd_in),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .hours    (hours),
    .minutes  (minutes),
    .seconds  (seconds)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int ndone  = 0;
  int cyc    = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: counts edges since start was sampled; decodes at edge 23.
  int          ph = 0;
  logic        m_busy = 0, m_done = 0, m_err = 0;
  int          m_h = 0, m_m = 0, m_s = 0;
  logic [23:0] cap = '0;
  bit          bad;
  int          hh, mm, ss;

  initial begin
    forever begin
      @(posedge CLOCK_50 or posedge reset);
      if (reset) begin
        ph = 0; m_busy = 0; m_done = 0; m_err = 0;
        m_h = 0; m_m = 0; m_s = 0;
      end else begin
        m_done = 0;
        m_err  = 0;
        if (ph == 0) begin
          m_busy = start;
          if (start) ph = 1;
        end else begin
          if (ph == 1) cap = bcd_in;
          if (ph == 23) begin
            bad = 0;
            for (int i = 0; i < 6; i++)
              if (cap[4*i +: 4] > 9) bad = 1;
            ss = cap[7:4] * 10 + cap[3:0];
            mm = cap[15:12] * 10 + cap[11:8];
            hh = cap[23:20] * 10 + cap[19:16];
            m_err = bad || mm > 59 || ss > 59 || hh > HLIM;
            m_done = 1;
            if (!m_err) begin
              m_h = hh; m_m = mm; m_s = ss;
            end
            ph = 0;
          end else begin
            ph++;
          end
        end
      end
    end
  end

  always @(posedge CLOCK_50) cyc++;

  always @(negedge CLOCK_50) begin
    if (done === 1'b1) ndone++;
    if (cyc > 0) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("hours", hours, m_h);
      chk("minutes", minutes, m_m);
      chk("seconds", seconds, m_s);
    end
  end

  task automatic convert(input logic [23:0] v,
                         input bit scramble,
                         output logic e,
                         output logic [6:0] h,
                         output logic [6:0] m,
                         output logic [6:0] s);
    int n;
    bcd_in = v;
    start  = 1'b1;
    @(posedge CLOCK_50); #1 start = 1'b0;
    @(posedge CLOCK_50); #1;
    if (scramble) bcd_in = 24'($urandom);
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (done !== 1'b1 && n < 40);
    if (done !== 1'b1) chk("done_timeout", 0, 1);
    else chk("latency", n, 23);
    e = err; h = hours; m = minutes; s = seconds;
    @(posedge CLOCK_50); #1;
  endtask

  logic       re;
  logic [6:0] rh, rm, rs;
  int         n0;
  logic [23:0] v;

  initial begin
    repeat (3) @(posedge CLOCK_50);
    #1 reset = 1'b0;
    @(negedge CLOCK_50);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_hours", hours, 0);
    @(posedge CLOCK_50); #1;

    convert(24'h123456, 0, re, rh, rm, rs);
    chk("t1_err", re, 0);
    chk("t1_h", rh, 12);
    chk("t1_m", rm, 34);
    chk("t1_s", rs, 56);
    chk("t1_model_h", m_h, 12);

    convert(24'h126000, 1, re, rh, rm, rs);
    chk("min60_err", re, 1);
    chk("min60_hold_h", rh, 12);
    chk("min60_hold_s", rs, 56);

    convert(24'h995959, 0, re, rh, rm, rs);
`ifdef BCD_TIME_DECODER_HOURS24_EN
    chk("h99_err", re, 1);
`else
    chk("h99_err", re, 0);
    chk("h99_h", rh, 99);
    chk("h99_m", rm, 59);
    chk("h99_s", rs, 59);
`endif

    convert(24'h000000, 0, re, rh, rm, rs);
    chk("zero_err", re, 0);
    chk("zero_h", rh, 0);
    chk("zero_s", rs, 0);

    convert(24'h071508, 0, re, rh, rm, rs);
    chk("t2_h", rh, 7);
    chk("t2_m", rm, 15);

    convert(24'h12A400, 0, re, rh, rm, rs);
    chk("digit_err", re, 1);
    chk("digit_hold_h", rh, 7);

    convert(24'h240000, 0, re, rh, rm, rs);
`ifdef BCD_TIME_DECODER_HOURS24_EN
    chk("h24_err", re, 1);
    chk("h24_hold", rh, 7);
`else
    chk("h24_err", re, 0);
    chk("h24_h", rh, 24);
`endif

    // start re-pulsed mid-conversion must be ignored
    n0 = ndone;
    bcd_in = 24'h010203;
    start = 1'b1;
    @(posedge CLOCK_50); #1 start = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #1 start = 1'b1;
    @(posedge CLOCK_50); #1 start = 1'b0;
    repeat (40) @(posedge CLOCK_50);
    #1;
    chk("repulse_dones", ndone - n0, 1);
    chk("repulse_s", seconds, 3);

    // reset mid-conversion aborts with no done
    bcd_in = 24'h111111;
    start = 1'b1;
    @(posedge CLOCK_50); #1 start = 1'b0;
    repeat (9) @(posedge CLOCK_50);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hours", hours, 0);
    n0 = ndone;
    repeat (3) @(posedge CLOCK_50);
    #1 reset = 1'b0;
    repeat (30) @(posedge CLOCK_50);
    #1;
    chk("abort_no_done", ndone - n0, 0);

    convert(24'h235959, 0, re, rh, rm, rs);
    chk("post_rst_err", re, 0);
    chk("post_rst_h", rh, 23);
    chk("post_rst_s", rs, 59);

    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge CLOCK_50);
      #1;
      if ($urandom_range(0, 3) == 0) begin
        v = 24'($urandom);
      end else begin
        for (int d = 0; d < 6; d++)
          v[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      if (k % 25 == 24) begin
        start = 1'b1;
        repeat (60) begin
          bcd_in = 24'($urandom);
          @(posedge CLOCK_50); #1;
        end
        start = 1'b0;
        repeat (30) @(posedge CLOCK_50);
        #1;
      end else begin
        convert(v, 1'($urandom), re, rh, rm, rs);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
